// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: one request at a time,
// WAIT_CYCLES wait states, byte-enabled stores, registered load data and a pipeline stall.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so each request is taken exactly once.

  localparam int          IDXW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end
  if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        cap_write;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the commit edge is the acceptance edge, so the live inputs are used.
  logic            use_write;
  logic [31:0]     use_addr, use_wdata, offset;
  logic [3:0]      use_be;
  logic [IDXW-1:0] index;
  logic            acc_err, commit;

  assign use_write = (state == IDLE) ? req_write : cap_write;
  assign use_addr  = (state == IDLE) ? req_addr  : cap_addr;
  assign use_wdata = (state == IDLE) ? req_wdata : cap_wdata;
  assign use_be    = (state == IDLE) ? req_be    : cap_be;
  assign offset    = use_addr - BASE_ADDR;
  assign index     = offset[IDXW+1:2];
  assign acc_err   = (use_addr[1:0] != 2'b00) || (offset >= SPAN) ||
                     (use_write && (use_be == 4'b0000));
  assign commit    = (state != RESP) && (state_nxt == RESP);
  assign dbg_state = state;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      cap_write  <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      cap_be     <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req_valid) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_be    <= req_be;
      end
      if (commit) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || use_write) ? 32'd0 : mem[index];
        if (!acc_err && use_write) begin
          for (int b = 0; b < 4; b++)
            if (use_be[b]) mem[index][8*b +: 8] <= use_wdata[8*b +: 8];
        end
      end else if (state == RESP) begin
        resp_rdata <= 32'd0;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule
